// File: rtl/bitwise_logic_pkg.sv
// Shared types and helpers for the pipelined bitwise logic unit.
// The optional match counter (BITWISE_LOGIC_MATCH_CNT_EN) uses MATCH_CNT_W.
package bitwise_logic_pkg;

    localparam int MATCH_CNT_W = 16;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_XNOR  = 3'b011,
        OP_NAND  = 3'b100,
        OP_NOR   = 3'b101,
        OP_NOT_A = 3'b110,
        OP_PASS  = 3'b111
    } op_e;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bitwise_logic_core.sv
// Purely combinational opcode decode: bitwise result y and per-bit match mask m.
module bitwise_logic_core
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] m
);

    always_comb begin
        m = ~(a ^ b);
        y = a;
        unique case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_NOT_A: y = ~a;
            OP_PASS:  y = a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready bitwise logic unit with equality flag and matching-bit count.
// Define BITWISE_LOGIC_MATCH_CNT_EN to add the saturating match_cnt counter and cnt_clr.
module bitwise_logic_pipe
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIM_W = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [2:0]             op,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef BITWISE_LOGIC_MATCH_CNT_EN
    input  logic                   cnt_clr,
    output logic [MATCH_CNT_W-1:0] match_cnt,
`endif
    output logic [WIDTH-1:0]       y,
    output logic                   eq,
    output logic [SIM_W-1:0]       sim
);

    logic             v1_q, v1_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [WIDTH-1:0] m1_q, m1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] y2_q, y2_d;
    logic             eq2_q, eq2_d;
    logic [SIM_W-1:0] sim2_q, sim2_d;
    logic [WIDTH-1:0] core_y, core_m;
    logic             ready2;
    logic             in_xfer;

    bitwise_logic_core #(.WIDTH(WIDTH)) u_core (
        .a  (a),
        .b  (b),
        .op (op_e'(op)),
        .y  (core_y),
        .m  (core_m)
    );

    // Readiness ripples backwards from the consumer so a full pipe still streams.
    assign ready2   = !v2_q || out_ready;
    assign in_ready = !v1_q || ready2;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        v1_d   = v1_q;
        y1_d   = y1_q;
        m1_d   = m1_q;
        v2_d   = v2_q;
        y2_d   = y2_q;
        eq2_d  = eq2_q;
        sim2_d = sim2_q;
        if (in_xfer) begin
            v1_d = 1'b1;
            y1_d = core_y;
            m1_d = core_m;
        end else if (ready2) begin
            v1_d = 1'b0;
        end
        if (ready2) begin
            v2_d = v1_q;
            if (v1_q) begin
                y2_d   = y1_q;
                eq2_d  = &m1_q;
                sim2_d = SIM_W'(popcount(64'(m1_q)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            y1_q   <= '0;
            m1_q   <= '0;
            v2_q   <= 1'b0;
            y2_q   <= '0;
            eq2_q  <= 1'b0;
            sim2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            y1_q   <= y1_d;
            m1_q   <= m1_d;
            v2_q   <= v2_d;
            y2_q   <= y2_d;
            eq2_q  <= eq2_d;
            sim2_q <= sim2_d;
        end
    end

    assign out_valid = v2_q;
    assign y         = y2_q;
    assign eq        = eq2_q;
    assign sim       = sim2_q;

`ifdef BITWISE_LOGIC_MATCH_CNT_EN
    logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic                   out_xfer;

    assign out_xfer = v2_q && out_ready;

    // Clear wins over a coincident count; the count sticks at all-ones.
    always_comb begin
        match_cnt_d = match_cnt_q;
        if (cnt_clr) begin
            match_cnt_d = '0;
        end else if (out_xfer && eq2_q && (match_cnt_q != '1)) begin
            match_cnt_d = match_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_q <= '0;
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign match_cnt = match_cnt_q;
`else
    // Counter not built: outputs come straight from stage 2 only.
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed and randomized bench for bitwise_logic_pipe at WIDTH 8, 13 and 1.
// Counter checks are compiled in when BITWISE_LOGIC_MATCH_CNT_EN is defined.
module tb_bitwise_logic_pipe;

    typedef struct {
        logic [63:0] y;
        logic        eq;
        int          sim;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  op;
    logic [7:0]  a8, b8, y8;
    logic [12:0] a13, b13, y13;
    logic        a1, b1, y1;
    logic        in_ready8, in_ready13, in_ready1;
    logic        out_valid8, out_valid13, out_valid1;
    logic        eq8, eq13, eq1;
    logic [3:0]  sim8, sim13;
    logic [0:0]  sim1;
`ifdef BITWISE_LOGIC_MATCH_CNT_EN
    logic        cnt_clr;
    logic [15:0] mc8, mc13, mc1;
`endif

    int n_vec = 0;
    int n_err = 0;
    exp_t q8[$], q13[$], q1[$];

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op), .out_valid(out_valid8), .out_ready(out_ready),
`ifdef BITWISE_LOGIC_MATCH_CNT_EN
        .cnt_clr(cnt_clr), .match_cnt(mc8),
`endif
        .y(y8), .eq(eq8), .sim(sim8)
    );

    bitwise_logic_pipe #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready13),
        .a(a13), .b(b13), .op(op), .out_valid(out_valid13), .out_ready(out_ready),
`ifdef BITWISE_LOGIC_MATCH_CNT_EN
        .cnt_clr(cnt_clr), .match_cnt(mc13),
`endif
        .y(y13), .eq(eq13), .sim(sim13)
    );

    bitwise_logic_pipe #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
`ifdef BITWISE_LOGIC_MATCH_CNT_EN
        .cnt_clr(cnt_clr), .match_cnt(mc1),
`endif
        .y(y1), .eq(eq1), .sim(sim1)
    );

    function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                   input logic [2:0] o, input int w);
        exp_t e;
        logic [63:0] r;
        case (o)
            3'd0:    r = av & bv;
            3'd1:    r = av | bv;
            3'd2:    r = av ^ bv;
            3'd3:    r = ~(av ^ bv);
            3'd4:    r = ~(av & bv);
            3'd5:    r = ~(av | bv);
            3'd6:    r = ~av;
            default: r = av;
        endcase
        e.y   = r;
        e.sim = 0;
        for (int i = 0; i < w; i++) begin
            if (av[i] == bv[i]) e.sim++;
        end
        e.eq = (e.sim == w);
        return e;
    endfunction

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0;
        a8 = '0; b8 = '0; a13 = '0; b13 = '0; a1 = 1'b0; b1 = 1'b0;
`ifdef BITWISE_LOGIC_MATCH_CNT_EN
        cnt_clr = 1'b0;
`endif
        #3;
        n_vec++;
        if ({out_valid8, y8, eq8, sim8} !== 14'h0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got %h, want %h", {out_valid8, y8, eq8, sim8}, 14'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({in_ready8, out_valid8, out_valid13, out_valid1} !== 4'b1000) begin
            n_err++;
            $display("[TB] FAIL reset_release: got %b, want %b",
                     {in_ready8, out_valid8, out_valid13, out_valid1}, 4'b1000);
        end
    endtask

    task automatic test_opcodes();
        logic [7:0] exp_y [8];
        exp_y = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h5A, 8'hA5};
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                in_valid = 1'b1; a8 = 8'hA5; b8 = 8'h0F; op = 3'(c);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 2) begin
                n_vec++;
                if ({out_valid8, y8, eq8, sim8} !== {1'b1, exp_y[c-2], 1'b0, 4'd4}) begin
                    n_err++;
                    $display("[TB] FAIL opcode_%0d: got %h, want %h", c - 2,
                             {out_valid8, y8, eq8, sim8}, {1'b1, exp_y[c-2], 1'b0, 4'd4});
                end
            end
        end
    endtask

    task automatic test_equality();
        logic [13:0] exp_o [2];
        exp_o = '{{1'b1, 8'hFF, 1'b1, 4'd8}, {1'b1, 8'h00, 1'b0, 4'd0}};
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = (c < 2);
            op = 3'b011;
            a8 = (c == 0) ? 8'h3C : 8'h00;
            b8 = (c == 0) ? 8'h3C : 8'hFF;
            #1;
            if (c >= 2) begin
                n_vec++;
                if ({out_valid8, y8, eq8, sim8} !== exp_o[c-2]) begin
                    n_err++;
                    $display("[TB] FAIL equality_%0d: got %h, want %h", c - 2,
                             {out_valid8, y8, eq8, sim8}, exp_o[c-2]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0]  ia [3];
        logic [7:0]  ib [3];
        logic [2:0]  iop [3];
        logic [13:0] eo [3];
        int          k;
        ia  = '{8'h11, 8'hF0, 8'h0F};
        ib  = '{8'h22, 8'hFF, 8'h0F};
        iop = '{3'b001, 3'b000, 3'b010};
        eo  = '{{1'b1, 8'h33, 1'b0, 4'd4}, {1'b1, 8'hF0, 1'b0, 4'd4}, {1'b1, 8'h00, 1'b1, 4'd8}};
        drain();
        out_ready = 1'b0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            k = (c < 2) ? c : 2;
            in_valid = (c < 8);
            a8 = ia[k]; b8 = ib[k]; op = iop[k];
            if (c >= 7) out_ready = 1'b1;
            #1;
            n_vec++;
            if (in_ready8 !== ((c < 2) || (c >= 7))) begin
                n_err++;
                $display("[TB] FAIL stall_in_ready_c%0d: got %b, want %b", c, in_ready8,
                         ((c < 2) || (c >= 7)));
            end
            if (c >= 2 && c <= 9) begin
                k = (c <= 7) ? 0 : c - 7;
                n_vec++;
                if ({out_valid8, y8, eq8, sim8} !== eo[k]) begin
                    n_err++;
                    $display("[TB] FAIL stall_out_c%0d: got %h, want %h", c,
                             {out_valid8, y8, eq8, sim8}, eo[k]);
                end
            end else if (c == 10) begin
                n_vec++;
                if (out_valid8 !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL stall_no_dup: got %b, want 0", out_valid8);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drain();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; a8 = 8'h12; b8 = 8'h34; op = 3'b000;
        @(negedge clk);
        a8 = 8'h56; b8 = 8'h78;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid8 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL areset_full: got %b, want 1", out_valid8);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid8, y8, eq8, sim8} !== 14'h0) begin
            n_err++;
            $display("[TB] FAIL areset_clear: got %h, want %h", {out_valid8, y8, eq8, sim8}, 14'h0);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; a8 = 8'h5A; b8 = 8'h5A; op = 3'b111;
        #1;
        n_vec++;
        if ({in_ready8, out_valid8} !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL areset_ready: got %b, want 10", {in_ready8, out_valid8});
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid8 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL areset_lat1: got %b, want 0", out_valid8);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if ({out_valid8, y8, eq8, sim8} !== {1'b1, 8'h5A, 1'b1, 4'd8}) begin
            n_err++;
            $display("[TB] FAIL areset_lat2: got %h, want %h", {out_valid8, y8, eq8, sim8},
                     {1'b1, 8'h5A, 1'b1, 4'd8});
        end
    endtask

    task automatic test_random(input int n_txn);
        int   accepted;
        int   cycles;
        exp_t e;
        accepted = 0;
        cycles   = 0;
        drain();
        q8.delete(); q13.delete(); q1.delete();
        while ((accepted < n_txn || q8.size() != 0 || q13.size() != 0 || q1.size() != 0)
               && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            in_valid  = (accepted < n_txn) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            op  = 3'($urandom_range(0, 7));
            a8  = 8'($urandom);
            b8  = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
            a13 = 13'($urandom);
            b13 = ($urandom_range(0, 3) == 0) ? a13 : 13'($urandom);
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            #1;
            if (out_valid8 && out_ready) begin
                n_vec++;
                if (q8.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL rand8_extra: got y=%h, want no output", y8);
                end else begin
                    e = q8.pop_front();
                    if ({y8, eq8, sim8} !== {e.y[7:0], e.eq, 4'(e.sim)}) begin
                        n_err++;
                        $display("[TB] FAIL rand8: got %h, want %h", {y8, eq8, sim8},
                                 {e.y[7:0], e.eq, 4'(e.sim)});
                    end
                end
            end
            if (out_valid13 && out_ready) begin
                n_vec++;
                if (q13.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL rand13_extra: got y=%h, want no output", y13);
                end else begin
                    e = q13.pop_front();
                    if ({y13, eq13, sim13} !== {e.y[12:0], e.eq, 4'(e.sim)}) begin
                        n_err++;
                        $display("[TB] FAIL rand13: got %h, want %h", {y13, eq13, sim13},
                                 {e.y[12:0], e.eq, 4'(e.sim)});
                    end
                end
            end
            if (out_valid1 && out_ready) begin
                n_vec++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL rand1_extra: got y=%b, want no output", y1);
                end else begin
                    e = q1.pop_front();
                    if ({y1, eq1, sim1} !== {e.y[0], e.eq, 1'(e.sim)} || eq1 !== sim1[0]) begin
                        n_err++;
                        $display("[TB] FAIL rand1: got %b, want %b", {y1, eq1, sim1},
                                 {e.y[0], e.eq, 1'(e.sim)});
                    end
                end
            end
            if (in_valid && in_ready8) begin
                q8.push_back(model(64'(a8), 64'(b8), op, 8));
                accepted++;
            end
            if (in_valid && in_ready13) q13.push_back(model(64'(a13), 64'(b13), op, 13));
            if (in_valid && in_ready1)  q1.push_back(model(64'(a1), 64'(b1), op, 1));
        end
        n_vec++;
        if (cycles >= 20000 || q8.size() != 0 || q13.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("[TB] FAIL rand_drain: got %0d cycles %0d pending, want < 20000 cycles 0 pending",
                     cycles, q8.size() + q13.size() + q1.size());
        end
    endtask

`ifdef BITWISE_LOGIC_MATCH_CNT_EN
    task automatic test_match_cnt();
        drain();
        a8 = 8'h00; b8 = 8'h00; a13 = '0; b13 = '0; a1 = 1'b0; b1 = 1'b0; op = 3'b000;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        n_vec++;
        if ({mc8, mc13, mc1} !== 48'h0) begin
            n_err++;
            $display("[TB] FAIL cnt_clear: got %h, want 0", {mc8, mc13, mc1});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a8 = 8'(8'h40 + i); b8 = a8;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({mc8, mc13, mc1} !== {16'd5, 16'd5, 16'd5}) begin
            n_err++;
            $display("[TB] FAIL cnt_five: got %h, want %h", {mc8, mc13, mc1}, {16'd5, 16'd5, 16'd5});
        end
        @(negedge clk);
        in_valid = 1'b1; a8 = 8'h77; b8 = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        cnt_clr = 1'b1;
        #1;
        n_vec++;
        if ({out_valid8, eq8} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL cnt_clr_setup: got %b, want 11", {out_valid8, eq8});
        end
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        n_vec++;
        if (mc8 !== 16'h0) begin
            n_err++;
            $display("[TB] FAIL cnt_clr_priority: got %h, want 0000", mc8);
        end
        @(negedge clk);
        force dut8.match_cnt_q = 16'hFFFE;
        #1 release dut8.match_cnt_q;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a8 = 8'h99; b8 = 8'h99;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (mc8 !== 16'hFFFF) begin
            n_err++;
            $display("[TB] FAIL cnt_saturate: got %h, want FFFF", mc8);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_opcodes();
        test_equality();
        test_stall();
        test_async_reset();
        test_random(1000);
`ifdef BITWISE_LOGIC_MATCH_CNT_EN
        test_match_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
